i2c_temp_target: RTL and testbench
==================================

// Module: i2c_temp_target
// PURPOSE
//  I2C target (slave) that emulates the board's temperature sensor, so the I2C master controller can be exercised in sim/FPGA loopback.
//  Decodes address, pointer-register write, 2-byte register writes and 2-byte register reads on open-drain SCL/SDA.
//  Sits between the I2C pads (or the master's bus model) and a local temperature source; exports config state to fabric.
// PARAMETERS
//  DEV_ADDR     7'h48     7-bit target address matched after START
//  CONF_RST     16'h60A0  reset value of config register (ptr 1)
//  TLOW_RST     16'h4B00  reset value of T_LOW register (ptr 2)
//  THIGH_RST    16'h5000  reset value of T_HIGH register (ptr 3)
// PORTS
//  clk         in   1   system clock; must be >= 16x SCL frequency
//  reset       in   1   asynchronous, active-high reset
//  scl_in      in   1   raw SCL from pad (async)
//  sda_in      in   1   raw SDA from pad (async)
//  sda_oe      out  1   1 = pull SDA low (open drain), 0 = release
//  temp_in     in   12  two's-complement temperature, 0.0625 C/LSB
//  config_out  out  16  current config register
//  wr_strobe   out  1   1-cycle pulse when a register write commits
//  wr_ptr      out  2   pointer of the committed write (valid with wr_strobe)
//  busy        out  1   1 from address match until STOP / NACK-release
// BEHAVIOUR
//  Reset: sda_oe=0, wr_strobe=0, wr_ptr=0, busy=0, config_out=CONF_RST, TLOW/THIGH=*_RST, ptr=0, state IDLE; async, any time.
//  Input path: scl_in/sda_in through 2-FF sync; edges taken on synced values (3-cycle latency to pad).
//  START = synced SDA fall while SCL high; STOP = SDA rise while SCL high. Both override every state.
//  Data sampled on SCL rise; target changes sda_oe only on SCL fall; no clock stretching.
//  States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
//   IDLE -START-> ADDR. ADDR shifts 8 bits MSB first (7 addr + R/W).
//   addr match -> ADDR_ACK: sda_oe=1 from 8th SCL fall to 9th SCL fall; busy=1.
//   mismatch -> WAIT_STOP, SDA never driven.
//   W=0 -> PTR: byte latched; ptr=byte[1:0], byte[7:2] ignored; ACK via PTR_ACK -> WR_BYTE.
//   WR_BYTE: bytes alternate MSB, LSB into a 16-bit holding reg; every byte ACKed.
//    On LSB ACK, write commits: reg[ptr] updated, wr_strobe=1 for one clk, wr_ptr=ptr.
//    Writes to ptr 0 (temp) are ACKed but discarded; no strobe. Pointer never auto-increments.
//   R=1 -> shadow = reg[ptr] latched on the 9th SCL fall of the addr byte.
//    temp reads return {temp_in,4'h0} snapshotted at the same edge, so MSB/LSB are coherent.
//    RD_BYTE drives shadow MSB then LSB: sda_oe = ~bit, first bit on the addr-ACK SCL fall.
//    RD_ACK releases SDA; samples master bit on 9th rise. ACK(0) -> next byte (MSB,LSB,MSB...).
//    NACK(1) -> WAIT_STOP, busy=0.
//  Repeated START in any state: -> ADDR, byte index cleared, held write MSB discarded, sda_oe=0 next clk.
//  STOP in any state: -> IDLE, sda_oe=0, busy=0. A partial write (MSB only) is discarded.
//  Bit counter 3 bits, wraps 7->0 at byte end. Holding regs 8 bits; register file 4x16 (ptr 0 read-only view).
//  START and STOP detected in the same clk is impossible (needs two SDA edges); STOP wins if seen first.
// STRUCTURE
//  Package i2c_pkg: target state enum; PTR_TEMP=0, PTR_CONF=1, PTR_TLOW=2, PTR_THIGH=3; shared with the controller side.
//  Sub-module i2c_line_sync: 2-FF sync of SCL/SDA, outputs scl_rise, scl_fall, start_det, stop_det pulses.
//  Top holds FSM, bit/byte counters, shift regs, register file.
// TESTING
//  T1 write 0x90,0x01,0x60,0xA0 (config) -> 4 ACKs, wr_strobe once with wr_ptr=1, config_out=16'h60A0.
//  T2 temp_in=12'h190: write 0x90,0x00; Sr; 0x91; read 2 bytes ACK/NACK -> 0x19,0x00 on SDA; busy drops at NACK.
//  T3 address 0x92 (wrong) -> no SDA drive entire transaction, busy stays 0, no wr_strobe.
//  T4 write 0x90,0x02,0x4B then STOP -> no strobe, TLOW unchanged; Sr mid-byte -> FSM restarts at ADDR.
//  T5 temp_in=12'hE70 (-25 C) changed mid-read -> bytes 0xE7,0x00 from snapshot; 3rd byte (ACKed) repeats 0xE7.
//  T6 reset asserted mid-read while sda_oe=1 -> sda_oe=0 immediately (async), all outputs to reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C target and controller sides.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_WAIT_STOP
    } target_state_t;

    localparam logic [1:0] PTR_TEMP  = 2'd0;
    localparam logic [1:0] PTR_CONF  = 2'd1;
    localparam logic [1:0] PTR_TLOW  = 2'd2;
    localparam logic [1:0] PTR_THIGH = 2'd3;

    // 12-bit temperature left-justified into the 16-bit register format.
    function automatic logic [15:0] temp_word(input logic [11:0] temp);
        return {temp, 4'h0};
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for raw SCL/SDA plus SCL edge, START and STOP pulses.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Flops come out of reset high, matching an idle bus, so no false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so each stage captures the pre-edge value of the one before it.
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sda_level = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] & scl_prev;
    assign start_det = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating the board temperature sensor: pointer register,
// 16-bit config/T_LOW/T_HIGH registers and a snapshotted temperature read.
module i2c_temp_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'h48,
    parameter logic [15:0] CONF_RST  = 16'h60A0,
    parameter logic [15:0] TLOW_RST  = 16'h4B00,
    parameter logic [15:0] THIGH_RST = 16'h5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] temp_in,
    output logic [15:0] config_out,
    output logic        wr_strobe,
    output logic [1:0]  wr_ptr,
    output logic        busy
);
    import i2c_pkg::*;

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    target_state_t state;
    logic [2:0]    bit_cnt;
    logic          byte_done;
    logic [7:0]    rx;
    logic [7:0]    tx;
    logic [7:0]    wr_msb;
    logic [15:0]   shadow;
    logic          lsb_next;
    logic          rw;
    logic [1:0]    ptr;
    logic [15:0]   conf_reg, tlow_reg, thigh_reg;
    logic [15:0]   rd_val;
    logic [7:0]    next_byte;

    always_comb begin
        // NOTE: default assignment first so no path leaves rd_val unassigned (no latch).
        rd_val = temp_word(temp_in);
        case (ptr)
            PTR_CONF:  rd_val = conf_reg;
            PTR_TLOW:  rd_val = tlow_reg;
            PTR_THIGH: rd_val = thigh_reg;
            default:   ;
        endcase
    end

    assign next_byte  = lsb_next ? shadow[7:0] : shadow[15:8];
    assign config_out = conf_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_ptr    <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            wr_msb    <= 8'h00;
            shadow    <= 16'h0000;
            lsb_next  <= 1'b0;
            rw        <= 1'b0;
            ptr       <= PTR_TEMP;
            // NOTE: only three small registers with defined power-on values, so they are reset; a real RAM would not be.
            conf_reg  <= CONF_RST;
            tlow_reg  <= TLOW_RST;
            thigh_reg <= THIGH_RST;
        end else begin
            wr_strobe <= 1'b0;
            if (stop_det) begin
                state     <= ST_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                lsb_next  <= 1'b0;
            end else if (start_det) begin
                state     <= ST_ADDR;
                sda_oe    <= 1'b0;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                lsb_next  <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    ST_ADDR, ST_PTR, ST_WR_BYTE, ST_RD_BYTE: begin
                        rx      <= {rx[6:0], sda_level};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done <= 1'b1;
                    end
                    ST_RD_ACK: begin
                        if (sda_level) begin
                            state <= ST_WAIT_STOP;
                            busy  <= 1'b0;
                        end else begin
                            byte_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ST_ADDR: if (byte_done) begin
                        byte_done <= 1'b0;
                        if (rx[7:1] == DEV_ADDR) begin
                            state  <= ST_ADDR_ACK;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                            rw     <= rx[0];
                        end else begin
                            state <= ST_WAIT_STOP;
                            busy  <= 1'b0;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (rw) begin
                            // Snapshot taken here keeps MSB and LSB of one read coherent.
                            shadow   <= rd_val;
                            sda_oe   <= ~rd_val[15];
                            tx       <= {rd_val[14:8], 1'b0};
                            lsb_next <= 1'b1;
                            state    <= ST_RD_BYTE;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_PTR: if (byte_done) begin
                        byte_done <= 1'b0;
                        ptr       <= rx[1:0];
                        sda_oe    <= 1'b1;
                        state     <= ST_PTR_ACK;
                    end
                    ST_PTR_ACK: begin
                        sda_oe   <= 1'b0;
                        lsb_next <= 1'b0;
                        state    <= ST_WR_BYTE;
                    end
                    ST_WR_BYTE: if (byte_done) begin
                        byte_done <= 1'b0;
                        sda_oe    <= 1'b1;
                        lsb_next  <= ~lsb_next;
                        state     <= ST_WR_ACK;
                        if (!lsb_next) begin
                            wr_msb <= rx;
                        end else if (ptr != PTR_TEMP) begin
                            wr_strobe <= 1'b1;
                            wr_ptr    <= ptr;
                            case (ptr)
                                PTR_CONF:  conf_reg  <= {wr_msb, rx};
                                PTR_TLOW:  tlow_reg  <= {wr_msb, rx};
                                PTR_THIGH: thigh_reg <= {wr_msb, rx};
                                default:   ;
                            endcase
                        end
                    end
                    ST_WR_ACK: begin
                        sda_oe <= 1'b0;
                        state  <= ST_WR_BYTE;
                    end
                    ST_RD_BYTE: begin
                        if (byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe    <= 1'b0;
                            state     <= ST_RD_ACK;
                        end else begin
                            sda_oe <= ~tx[7];
                            tx     <= {tx[6:0], 1'b0};
                        end
                    end
                    ST_RD_ACK: if (byte_done) begin
                        byte_done <= 1'b0;
                        sda_oe    <= ~next_byte[7];
                        tx        <= {next_byte[6:0], 1'b0};
                        lsb_next  <= ~lsb_next;
                        state     <= ST_RD_BYTE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_target.sv
// Bench for i2c_temp_target: bit-banged I2C master, scoreboard queues for ACKs and read bytes.
module tb_i2c_temp_target;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [11:0] temp_in;
    logic [15:0] config_out;
    logic        wr_strobe;
    logic [1:0]  wr_ptr;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int oe_cnt     = 0;
    int busy_cnt   = 0;
    logic [1:0] last_ptr = 2'd0;

    logic       exp_ack_q[$];
    logic [7:0] exp_byte_q[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_temp_target dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_in    (temp_in),
        .config_out (config_out),
        .wr_strobe  (wr_strobe),
        .wr_ptr     (wr_ptr),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (wr_strobe) begin
            strobe_cnt++;
            last_ptr = wr_ptr;
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1);
    end

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;
        quarter(); scl = 1'b1;
        quarter(); quarter(); scl = 1'b0;
        quarter();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1;
        quarter(); scl = 1'b1;
        quarter(); b = sda_line;
        quarter(); scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        quarter(); scl = 1'b1;
        quarter(); sda_m = 1'b0;
        quarter(); scl = 1'b0;
        quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        quarter(); scl = 1'b1;
        quarter(); sda_m = 1'b1;
        quarter();
    endtask

    task automatic send_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(data[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(input logic master_ack, output logic [7:0] data);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            data[i] = b;
        end
        put_bit(master_ack);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; temp_in = 12'h000;
        repeat (3) @(negedge clk);
        checks += 5;
        if (sda_oe !== 1'b0)          begin failures++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
        if (busy !== 1'b0)            begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (wr_strobe !== 1'b0)       begin failures++; $display("FAIL rst_wr_strobe: got %b expected 0", wr_strobe); end
        if (wr_ptr !== 2'd0)          begin failures++; $display("FAIL rst_wr_ptr: got %0d expected 0", wr_ptr); end
        if (config_out !== 16'h60A0)  begin failures++; $display("FAIL rst_config: got %h expected 60a0", config_out); end
        reset = 1'b0;
        quarter();
    endtask

    task automatic test_config_write();
        logic [7:0] wr [4];
        logic ack, e;
        logic [7:0] rd, erd;
        int s0;
        s0 = strobe_cnt;
        wr = '{8'h90, 8'h01, 8'h12, 8'h34};
        i2c_start();
        foreach (wr[i]) begin
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL cfg_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL cfg_busy_mid: got %b expected 1", busy); end
        i2c_stop();
        checks += 4;
        if (strobe_cnt - s0 != 1)    begin failures++; $display("FAIL cfg_strobes: got %0d expected 1", strobe_cnt - s0); end
        if (last_ptr !== 2'd1)       begin failures++; $display("FAIL cfg_wr_ptr: got %0d expected 1", last_ptr); end
        if (config_out !== 16'h1234) begin failures++; $display("FAIL cfg_value: got %h expected 1234", config_out); end
        if (busy !== 1'b0)           begin failures++; $display("FAIL cfg_busy_stop: got %b expected 0", busy); end

        // Read the config register back, then restore the default value.
        wr = '{8'h90, 8'h01, 8'h91, 8'h00};
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) i2c_start();
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL cfg_rd_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        exp_byte_q.push_back(8'h12); exp_byte_q.push_back(8'h34);
        for (int i = 0; i < 2; i++) begin
            recv_byte(i == 1, rd);
            erd = exp_byte_q.pop_front(); checks++;
            if (rd !== erd) begin failures++; $display("FAIL cfg_rd_byte[%0d]: got %h expected %h", i, rd, erd); end
        end
        i2c_stop();

        wr = '{8'h90, 8'h01, 8'h60, 8'hA0};
        i2c_start();
        foreach (wr[i]) begin
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL cfg2_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        i2c_stop();
        checks += 2;
        if (strobe_cnt - s0 != 2)    begin failures++; $display("FAIL cfg2_strobes: got %0d expected 2", strobe_cnt - s0); end
        if (config_out !== 16'h60A0) begin failures++; $display("FAIL cfg2_value: got %h expected 60a0", config_out); end
    endtask

    // Set pointer, repeated START, read n bytes (ACK all but last), compare against exp list.
    task automatic test_temp_read();
        logic [7:0] wr [3];
        logic ack, e;
        logic [7:0] rd, erd;
        temp_in = 12'h190;
        wr = '{8'h90, 8'h00, 8'h91};
        i2c_start();
        foreach (wr[i]) begin
            if (i == 2) i2c_start();
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL temp_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        exp_byte_q.push_back(8'h19); exp_byte_q.push_back(8'h00);
        for (int i = 0; i < 2; i++) begin
            recv_byte(i == 1, rd);
            erd = exp_byte_q.pop_front(); checks++;
            if (rd !== erd) begin failures++; $display("FAIL temp_byte[%0d]: got %h expected %h", i, rd, erd); end
        end
        checks += 2;
        if (busy !== 1'b0)   begin failures++; $display("FAIL temp_busy_nack: got %b expected 0", busy); end
        if (sda_oe !== 1'b0) begin failures++; $display("FAIL temp_oe_nack: got %b expected 0", sda_oe); end
        i2c_stop();
    endtask

    task automatic test_wrong_addr();
        logic [7:0] wr [3];
        logic ack, e;
        int s0, o0, b0;
        s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
        wr = '{8'h92, 8'h01, 8'h55};
        i2c_start();
        foreach (wr[i]) begin
            exp_ack_q.push_back(1'b1);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL wrong_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        i2c_stop();
        checks += 3;
        if (oe_cnt != o0)     begin failures++; $display("FAIL wrong_sda_driven: got %0d cycles expected 0", oe_cnt - o0); end
        if (busy_cnt != b0)   begin failures++; $display("FAIL wrong_busy: got %0d cycles expected 0", busy_cnt - b0); end
        if (strobe_cnt != s0) begin failures++; $display("FAIL wrong_strobe: got %0d expected 0", strobe_cnt - s0); end
    endtask

    task automatic test_partial_and_restart();
        logic [7:0] wr [4];
        logic ack, e;
        logic [7:0] rd, erd;
        int s0;
        s0 = strobe_cnt;
        // Two MSB-only writes to T_LOW, then a full write to temp pointer: none may commit.
        for (int t = 0; t < 3; t++) begin
            wr = (t == 0) ? '{8'h90, 8'h02, 8'h4B, 8'h00} :
                 (t == 1) ? '{8'h90, 8'h02, 8'h12, 8'h00} : '{8'h90, 8'h00, 8'hAA, 8'h55};
            i2c_start();
            for (int i = 0; i < ((t == 2) ? 4 : 3); i++) begin
                exp_ack_q.push_back(1'b0);
                send_byte(wr[i], ack);
                e = exp_ack_q.pop_front(); checks++;
                if (ack !== e) begin failures++; $display("FAIL part%0d_ack[%0d]: got %b expected %b", t, i, ack, e); end
            end
            i2c_stop();
        end
        checks++;
        if (strobe_cnt != s0) begin failures++; $display("FAIL part_strobe: got %0d expected 0", strobe_cnt - s0); end

        // T_LOW readback, then an aborted T_HIGH write byte interrupted by repeated START.
        for (int t = 0; t < 2; t++) begin
            wr = (t == 0) ? '{8'h90, 8'h02, 8'h91, 8'h00} : '{8'h90, 8'h03, 8'h91, 8'h00};
            i2c_start();
            for (int i = 0; i < 3; i++) begin
                if (i == 2) begin
                    if (t == 1) for (int k = 0; k < 4; k++) put_bit(1'b1);
                    i2c_start();
                end
                exp_ack_q.push_back(1'b0);
                send_byte(wr[i], ack);
                e = exp_ack_q.pop_front(); checks++;
                if (ack !== e) begin failures++; $display("FAIL rb%0d_ack[%0d]: got %b expected %b", t, i, ack, e); end
            end
            exp_byte_q.push_back((t == 0) ? 8'h4B : 8'h50); exp_byte_q.push_back(8'h00);
            for (int i = 0; i < 2; i++) begin
                recv_byte(i == 1, rd);
                erd = exp_byte_q.pop_front(); checks++;
                if (rd !== erd) begin failures++; $display("FAIL rb%0d_byte[%0d]: got %h expected %h", t, i, rd, erd); end
            end
            i2c_stop();
        end
        checks++;
        if (strobe_cnt != s0) begin failures++; $display("FAIL restart_strobe: got %0d expected 0", strobe_cnt - s0); end
    endtask

    task automatic test_snapshot();
        logic [7:0] wr [3];
        logic ack, e;
        logic [7:0] rd, erd;
        temp_in = 12'hE70;
        wr = '{8'h90, 8'h00, 8'h91};
        i2c_start();
        foreach (wr[i]) begin
            if (i == 2) i2c_start();
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL snap_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        exp_byte_q.push_back(8'hE7); exp_byte_q.push_back(8'h00); exp_byte_q.push_back(8'hE7);
        for (int i = 0; i < 3; i++) begin
            recv_byte(i == 2, rd);
            if (i == 0) temp_in = 12'h123;
            erd = exp_byte_q.pop_front(); checks++;
            if (rd !== erd) begin failures++; $display("FAIL snap_byte[%0d]: got %h expected %h", i, rd, erd); end
        end
        i2c_stop();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] wr [4];
        logic ack, e;
        logic [7:0] rd, erd;
        wr = '{8'h90, 8'h01, 8'h0F, 8'h0F};
        i2c_start();
        foreach (wr[i]) begin
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL r6_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        i2c_stop();
        checks += 2;
        if (config_out !== 16'h0F0F) begin failures++; $display("FAIL r6_config: got %h expected 0f0f", config_out); end
        if (wr_ptr !== 2'd1)         begin failures++; $display("FAIL r6_wr_ptr: got %0d expected 1", wr_ptr); end

        temp_in = 12'h190;
        wr = '{8'h90, 8'h00, 8'h91, 8'h00};
        i2c_start();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) i2c_start();
            exp_ack_q.push_back(1'b0);
            send_byte(wr[i], ack);
            e = exp_ack_q.pop_front(); checks++;
            if (ack !== e) begin failures++; $display("FAIL r6_rd_ack[%0d]: got %b expected %b", i, ack, e); end
        end
        checks++;
        if (sda_oe !== 1'b1) begin failures++; $display("FAIL r6_driving: got %b expected 1", sda_oe); end
        @(negedge clk); #2 reset = 1'b1;
        #1;
        checks += 5;
        if (sda_oe !== 1'b0)         begin failures++; $display("FAIL r6_async_oe: got %b expected 0", sda_oe); end
        if (busy !== 1'b0)           begin failures++; $display("FAIL r6_async_busy: got %b expected 0", busy); end
        if (wr_strobe !== 1'b0)      begin failures++; $display("FAIL r6_async_strobe: got %b expected 0", wr_strobe); end
        if (wr_ptr !== 2'd0)         begin failures++; $display("FAIL r6_async_wr_ptr: got %0d expected 0", wr_ptr); end
        if (config_out !== 16'h60A0) begin failures++; $display("FAIL r6_async_config: got %h expected 60a0", config_out); end
        scl = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        quarter();

        // Pointer is back to 0 after reset: a bare read returns temperature.
        i2c_start();
        exp_ack_q.push_back(1'b0);
        send_byte(8'h91, ack);
        e = exp_ack_q.pop_front(); checks++;
        if (ack !== e) begin failures++; $display("FAIL r6_post_ack: got %b expected %b", ack, e); end
        exp_byte_q.push_back(8'h19); exp_byte_q.push_back(8'h00);
        for (int i = 0; i < 2; i++) begin
            recv_byte(i == 1, rd);
            erd = exp_byte_q.pop_front(); checks++;
            if (rd !== erd) begin failures++; $display("FAIL r6_post_byte[%0d]: got %h expected %h", i, rd, erd); end
        end
        i2c_stop();
    endtask

    initial begin
        test_reset();
        test_config_write();
        test_temp_read();
        test_wrong_addr();
        test_partial_and_restart();
        test_snapshot();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
